board_perm_gen: RTL and testbench

- Parametrised successor to the fixed 4-piece board selector: builds an N-piece starting board, i.e. a permutation of piece codes 0..N-1.
- Index mode: board chosen by a user index, decoded sequentially as a factoradic (lexicographic rank), so no lookup table is needed.
- Random mode: board drawn from an internal LFSR with per-digit rejection sampling.
- Sits between the board-select inputs and the game core; only accepts requests while game_status is CHOSE_BOARD.

---
 rtl/board_perm_gen_if.sv | 26 ++
 rtl/board_perm_gen.sv | 230 +++++++++++++++++++++++
 tb/tb_board_perm_gen.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/board_perm_gen_if.sv
// Board-select request/response bundle between the board-select front end
// (master) and the permutation generator (slave).
interface board_perm_gen_if #(
  parameter int N_PIECES = 4,
  parameter int PW       = 3,
  parameter int IDX_W    = 5
);
  logic [1:0]             game_status;
  logic                   set;
  logic                   random;
  logic [IDX_W-1:0]       num;
  logic [N_PIECES*PW-1:0] out;
  logic                   busy;
  logic                   done;
  logic                   err;

  modport master (
    output game_status, set, random, num,
    input  out, busy, done, err
  );

  modport slave (
    input  game_status, set, random, num,
    output out, busy, done, err
  );
endinterface

// File: rtl/board_perm_gen.sv
// Starting-board generator: produces an N-piece permutation of codes 0..N-1,
// either from a lexicographic rank (factoradic, one compare/subtract per
// cycle) or from an LFSR with per-digit rejection sampling.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for set while game_status is CHOSE_BOARD
// S_CALC  | derive digit d for slot i (subtract loop or LFSR sample)
// S_PLACE | move pool[d] into work[i], compact the pool
// S_LOAD  | publish work on out, pulse done
module board_perm_gen #(
  parameter int          N_PIECES  = 4,
  parameter int          PW        = 3,
  parameter int          IDX_W     = 5,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic            clk_d,
  input  logic            rst,
  board_perm_gen_if.slave bus
);

  localparam int DW = $clog2(N_PIECES);
  localparam int OW = N_PIECES * PW;

  // k! for k = 0..8, the full supported range of N_PIECES
  localparam int unsigned FACT [0:8] = '{1, 1, 2, 6, 24, 120, 720, 5040, 40320};
  localparam logic [IDX_W:0] FACT_N = (IDX_W+1)'(FACT[N_PIECES]);
  localparam logic [DW-1:0]  LAST_I = DW'(N_PIECES - 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_PLACE = 2'd2,
    S_LOAD  = 2'd3
  } state_t;

  function automatic logic [OW-1:0] identity_board();
    logic [OW-1:0] b;
    b = '0;
    for (int k = 0; k < N_PIECES; k++) begin
      b[(N_PIECES-1-k)*PW +: PW] = PW'(k);
    end
    return b;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;

  logic [15:0]      r_lfsr;
  logic             w_lfsr_fb;
  logic [DW-1:0]    w_s;
  logic [DW:0]      w_left;
  logic             w_s_ok;

  logic [OW-1:0]    r_out;
  logic [OW-1:0]    w_work_flat;
  logic [PW-1:0]    r_work    [N_PIECES];
  logic [PW-1:0]    r_pool    [N_PIECES];
  logic [PW-1:0]    w_pool_rm [N_PIECES];
  logic [PW-1:0]    w_pick;

  logic [IDX_W-1:0] r_rem;
  logic [IDX_W-1:0] w_fact;
  logic [DW-1:0]    r_i;
  logic [DW-1:0]    r_d;
  logic             r_mode;
  logic             r_err;

  logic             w_active;
  logic             w_num_bad;
  logic             w_last;
  logic             w_start;
  logic             w_reject;
  logic             w_sub;
  logic             w_take_s;
  logic             w_place;
  logic             w_load;

  assign w_active  = (bus.game_status == 2'b00);
  assign w_num_bad = ({1'b0, bus.num} >= FACT_N);
  assign w_last    = (r_i == LAST_I);

  // Fibonacci taps 16,14,13,11; sample is the low DW bits
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_s       = r_lfsr[DW-1:0];
  assign w_left    = (DW+1)'(N_PIECES) - {1'b0, r_i};
  assign w_s_ok    = ({1'b0, w_s} < w_left);

  // Weight of the current digit: (N-1-i)!
  always_comb begin
    w_fact = '0;
    for (int k = 0; k < N_PIECES; k++) begin
      if (r_i == DW'(k)) w_fact = IDX_W'(FACT[N_PIECES-1-k]);
    end
  end

  // Selected pool entry and the pool with that entry removed (higher ones slide down)
  always_comb begin
    w_pick = '0;
    for (int k = 0; k < N_PIECES; k++) begin
      if (r_d == DW'(k)) w_pick = r_pool[k];
    end
    for (int k = 0; k < N_PIECES; k++) begin
      w_pool_rm[k] = r_pool[k];
    end
    for (int k = 0; k < N_PIECES - 1; k++) begin
      if (DW'(k) >= r_d) w_pool_rm[k] = r_pool[k+1];
    end
    w_pool_rm[N_PIECES-1] = '0;
  end

  // Flatten the work slots, slot 0 in the MSBs
  always_comb begin
    w_work_flat = '0;
    for (int k = 0; k < N_PIECES; k++) begin
      w_work_flat[(N_PIECES-1-k)*PW +: PW] = r_work[k];
    end
  end

  // State register
  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and datapath strobes; leaving CHOSE_BOARD aborts any generation
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_reject    = 1'b0;
    w_sub       = 1'b0;
    w_take_s    = 1'b0;
    w_place     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.set && w_active) begin
          if (!bus.random && w_num_bad) begin
            w_reject = 1'b1;
          end else begin
            w_start     = 1'b1;
            w_state_nxt = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (!w_active) begin
          w_state_nxt = S_IDLE;
        end else if (r_mode) begin
          if (w_s_ok) begin
            w_take_s    = 1'b1;
            w_state_nxt = S_PLACE;
          end
        end else if (r_rem >= w_fact) begin
          w_sub = 1'b1;
        end else begin
          w_state_nxt = S_PLACE;
        end
      end
      S_PLACE: begin
        if (!w_active) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_place     = 1'b1;
          w_state_nxt = w_last ? S_LOAD : S_CALC;
        end
      end
      S_LOAD: begin
        w_load      = w_active;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // LFSR, rank/digit counters, pool/work slots and the published board
  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
      r_out  <= identity_board();
      r_rem  <= '0;
      r_i    <= '0;
      r_d    <= '0;
      r_mode <= 1'b0;
      r_err  <= 1'b0;
      for (int k = 0; k < N_PIECES; k++) begin
        r_pool[k] <= PW'(k);
        r_work[k] <= PW'(k);
      end
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
      r_err  <= w_reject;
      if (w_start) begin
        r_mode <= bus.random;
        r_rem  <= bus.num;
        r_i    <= '0;
        r_d    <= '0;
        for (int k = 0; k < N_PIECES; k++) begin
          r_pool[k] <= PW'(k);
        end
      end
      if (w_sub) begin
        r_rem <= r_rem - w_fact;
        r_d   <= r_d + 1'b1;
      end
      if (w_take_s) begin
        r_d <= w_s;
      end
      if (w_place) begin
        for (int k = 0; k < N_PIECES; k++) begin
          if (r_i == DW'(k)) r_work[k] <= w_pick;
          r_pool[k] <= w_pool_rm[k];
        end
        // with one code left, it can only go in the final slot
        if (w_last) r_work[N_PIECES-1] <= w_pool_rm[0];
        else        r_i <= r_i + 1'b1;
        r_d <= '0;
      end
      if (w_load) begin
        r_out <= w_work_flat;
      end
    end
  end

  assign bus.out  = r_out;
  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = w_load;
  assign bus.err  = r_err;

endmodule

// File: tb/tb_board_perm_gen.sv
// Directed bench for board_perm_gen: N=4 and N=5 instances on one clock.
module tb_board_perm_gen;

  logic clk_d = 1'b0;
  logic rst;

  always #5 clk_d = ~clk_d;

  board_perm_gen_if #(.N_PIECES(4), .PW(3), .IDX_W(5)) if4 ();
  board_perm_gen_if #(.N_PIECES(5), .PW(3), .IDX_W(7)) if5 ();

  board_perm_gen #(.N_PIECES(4), .PW(3), .IDX_W(5), .LFSR_SEED(16'hACE1)) u_dut4 (
    .clk_d (clk_d),
    .rst   (rst),
    .bus   (if4.slave)
  );

  board_perm_gen #(.N_PIECES(5), .PW(3), .IDX_W(7), .LFSR_SEED(16'hACE1)) u_dut5 (
    .clk_d (clk_d),
    .rst   (rst),
    .bus   (if5.slave)
  );

  int checks   = 0;
  int failures = 0;
  bit seen [4096];

  // Issue one request on the N=4 instance and follow it until busy drops.
  // hold > 0 keeps set asserted (with a different num) while busy.
  task automatic run_req(input bit mode, input logic [4:0] v, input int hold,
                         output int busy_n, output int done_n, output int out_chg,
                         output bit timed_out);
    logic [11:0] prev;
    @(negedge clk_d);
    prev = if4.out;
    if4.set = 1'b1; if4.random = mode; if4.num = v;
    @(posedge clk_d); #1;
    busy_n = 0; done_n = 0; out_chg = 0; timed_out = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (c < hold) begin if4.set = 1'b1; if4.num = 5'd0; end
      else if4.set = 1'b0;
      if (!if4.busy) begin timed_out = 1'b0; break; end
      busy_n++;
      if (if4.done) done_n++;
      if (if4.out !== prev) out_chg++;
      @(posedge clk_d); #1;
    end
    if4.set = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    @(negedge clk_d); rst = 1'b0;
    repeat (20) @(posedge clk_d);
    #1;
    checks++; if (if4.out !== 12'h053) begin failures++; $display("FAIL reset_out: got %h expected %h", if4.out, 12'h053); end
    checks++; if (if4.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", if4.busy); end
    checks++; if (if4.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", if4.done); end
    checks++; if (if4.err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", if4.err); end
    checks++; if (if5.out !== 15'o01234) begin failures++; $display("FAIL reset_out5: got %o expected %o", if5.out, 15'o01234); end
  endtask

  task automatic test_index();
    logic [4:0]  vnum [6] = '{5'd23, 5'd0,    5'd9,    5'd11,   5'd5,    5'd23};
    logic [11:0] vexp [6] = '{12'h688, 12'h053, 12'h298, 12'h2D0, 12'h0D1, 12'h688};
    int          vlat [6] = '{13,    7,      10,      11,      10,      13};
    int bn, dn, oc;
    bit to;
    for (int t = 0; t < 6; t++) begin
      run_req(1'b0, vnum[t], 0, bn, dn, oc, to);
      checks++; if (to) begin failures++; $display("FAIL index_timeout[%0d]: busy never dropped", vnum[t]); end
      checks++; if (if4.out !== vexp[t]) begin failures++; $display("FAIL index_out[%0d]: got %h expected %h", vnum[t], if4.out, vexp[t]); end
      checks++; if (bn != vlat[t]) begin failures++; $display("FAIL index_latency[%0d]: got %0d expected %0d", vnum[t], bn, vlat[t]); end
      checks++; if (dn != 1) begin failures++; $display("FAIL index_done[%0d]: got %0d pulses expected 1", vnum[t], dn); end
      checks++; if (oc != 0) begin failures++; $display("FAIL index_out_early[%0d]: out moved %0d cycles while busy", vnum[t], oc); end
    end
  endtask

  task automatic test_index_err();
    logic [11:0] prev;
    prev = if4.out;
    @(negedge clk_d); if4.set = 1'b1; if4.random = 1'b0; if4.num = 5'd24;
    @(posedge clk_d); #1; if4.set = 1'b0;
    checks++; if (if4.err !== 1'b1) begin failures++; $display("FAIL err_pulse: got %b expected 1", if4.err); end
    checks++; if (if4.busy !== 1'b0) begin failures++; $display("FAIL err_busy: got %b expected 0", if4.busy); end
    @(posedge clk_d); #1;
    checks++; if (if4.err !== 1'b0) begin failures++; $display("FAIL err_one_cycle: got %b expected 0", if4.err); end
    checks++; if (if4.out !== prev) begin failures++; $display("FAIL err_out: got %h expected %h", if4.out, prev); end
    // not CHOSE_BOARD: both a bad and a good index are ignored
    for (int s = 1; s < 4; s++) begin
      @(negedge clk_d); if4.game_status = 2'(s); if4.set = 1'b1; if4.num = 5'd24;
      @(posedge clk_d); #1;
      checks++; if (if4.err !== 1'b0) begin failures++; $display("FAIL err_status%0d: got %b expected 0", s, if4.err); end
      if4.num = 5'd3;
      @(posedge clk_d); #1;
      checks++; if (if4.busy !== 1'b0) begin failures++; $display("FAIL busy_status%0d: got %b expected 0", s, if4.busy); end
      if4.set = 1'b0;
    end
    @(negedge clk_d); if4.game_status = 2'b00;
  endtask

  task automatic test_random();
    int bn, dn, oc, total_done, distinct, max_busy, min_busy;
    bit to, ok;
    logic [7:0] m;
    logic [2:0] code;
    total_done = 0; distinct = 0; max_busy = 0; min_busy = 1000;
    for (int k = 0; k < 4096; k++) seen[k] = 1'b0;
    for (int r = 0; r < 200; r++) begin
      run_req(1'b1, 5'($urandom_range(0, 31)), 0, bn, dn, oc, to);
      total_done += dn;
      if (bn > max_busy) max_busy = bn;
      if (bn < min_busy) min_busy = bn;
      ok = 1'b1; m = '0;
      for (int k = 0; k < 4; k++) begin
        code = if4.out[(3-k)*3 +: 3];
        if (code > 3'd3 || m[code]) ok = 1'b0;
        m[code] = 1'b1;
      end
      checks++; if (to || !ok || m !== 8'h0F) begin failures++; $display("FAIL random_perm[%0d]: got %h timeout=%b", r, if4.out, to); end
      if (!seen[if4.out]) begin seen[if4.out] = 1'b1; distinct++; end
      repeat ($urandom_range(0, 5)) @(posedge clk_d);
    end
    checks++; if (total_done != 200) begin failures++; $display("FAIL random_done_count: got %0d expected 200", total_done); end
    checks++; if (distinct < 12) begin failures++; $display("FAIL random_distinct: got %0d expected >=12", distinct); end
    checks++; if (max_busy > 64) begin failures++; $display("FAIL random_max_busy: got %0d expected <=64", max_busy); end
    checks++; if (min_busy < 7) begin failures++; $display("FAIL random_min_busy: got %0d expected >=7", min_busy); end
  endtask

  task automatic test_set_while_busy();
    int bn, dn, oc;
    bit to;
    run_req(1'b0, 5'd0, 0, bn, dn, oc, to);
    run_req(1'b0, 5'd23, 5, bn, dn, oc, to);
    checks++; if (if4.out !== 12'h688) begin failures++; $display("FAIL busy_set_out: got %h expected %h", if4.out, 12'h688); end
    checks++; if (bn != 13) begin failures++; $display("FAIL busy_set_latency: got %0d expected 13", bn); end
    checks++; if (dn != 1) begin failures++; $display("FAIL busy_set_done: got %0d expected 1", dn); end
    repeat (3) @(posedge clk_d); #1;
    checks++; if (if4.busy !== 1'b0) begin failures++; $display("FAIL busy_set_restart: got %b expected 0", if4.busy); end
  endtask

  task automatic test_abort();
    int bn, dn, oc, done_seen;
    bit to;
    run_req(1'b0, 5'd0, 0, bn, dn, oc, to);
    @(negedge clk_d); if4.set = 1'b1; if4.random = 1'b0; if4.num = 5'd23;
    @(posedge clk_d); #1; if4.set = 1'b0;
    @(posedge clk_d); #1;
    checks++; if (if4.busy !== 1'b1) begin failures++; $display("FAIL abort_started: got %b expected 1", if4.busy); end
    @(negedge clk_d); if4.game_status = 2'b01;
    @(posedge clk_d); #1;
    checks++; if (if4.busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", if4.busy); end
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (if4.done) done_seen++;
      @(posedge clk_d); #1;
    end
    checks++; if (done_seen != 0) begin failures++; $display("FAIL abort_done: got %0d pulses expected 0", done_seen); end
    checks++; if (if4.out !== 12'h053) begin failures++; $display("FAIL abort_out: got %h expected %h", if4.out, 12'h053); end
    @(negedge clk_d); if4.game_status = 2'b00;
  endtask

  task automatic test_rst_mid();
    int bn, dn, oc;
    bit to;
    run_req(1'b0, 5'd23, 0, bn, dn, oc, to);
    @(negedge clk_d); if4.set = 1'b1; if4.random = 1'b0; if4.num = 5'd9;
    @(posedge clk_d); #1; if4.set = 1'b0;
    repeat (3) @(posedge clk_d);
    @(negedge clk_d); rst = 1'b1;
    #1;
    checks++; if (if4.out !== 12'h053) begin failures++; $display("FAIL rst_mid_out: got %h expected %h", if4.out, 12'h053); end
    checks++; if (if4.busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b expected 0", if4.busy); end
    checks++; if (if4.done !== 1'b0) begin failures++; $display("FAIL rst_mid_done: got %b expected 0", if4.done); end
    @(negedge clk_d); rst = 1'b0;
    repeat (3) @(posedge clk_d); #1;
    checks++; if (if4.busy !== 1'b0 || if4.out !== 12'h053) begin failures++; $display("FAIL rst_mid_after: got busy=%b out=%h expected 0/%h", if4.busy, if4.out, 12'h053); end
  endtask

  task automatic test_n5();
    logic [6:0]  vnum [2] = '{7'd119, 7'd0};
    logic [14:0] vexp [2] = '{15'o43210, 15'o01234};
    int          vlat [2] = '{19, 9};
    logic [14:0] prev;
    int bn, dn;
    bit to;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk_d); if5.set = 1'b1; if5.random = 1'b0; if5.num = vnum[t];
      @(posedge clk_d); #1; if5.set = 1'b0;
      bn = 0; dn = 0; to = 1'b1;
      for (int c = 0; c < 100; c++) begin
        if (!if5.busy) begin to = 1'b0; break; end
        bn++;
        if (if5.done) dn++;
        @(posedge clk_d); #1;
      end
      checks++; if (to || if5.out !== vexp[t]) begin failures++; $display("FAIL n5_out[%0d]: got %o expected %o timeout=%b", vnum[t], if5.out, vexp[t], to); end
      checks++; if (bn != vlat[t] || dn != 1) begin failures++; $display("FAIL n5_latency[%0d]: got %0d cycles %0d done expected %0d/1", vnum[t], bn, dn, vlat[t]); end
    end
    prev = if5.out;
    @(negedge clk_d); if5.set = 1'b1; if5.num = 7'd120;
    @(posedge clk_d); #1; if5.set = 1'b0;
    checks++; if (if5.err !== 1'b1 || if5.busy !== 1'b0) begin failures++; $display("FAIL n5_err: got err=%b busy=%b expected 1/0", if5.err, if5.busy); end
    @(posedge clk_d); #1;
    checks++; if (if5.out !== prev || if5.err !== 1'b0) begin failures++; $display("FAIL n5_err_after: got out=%o err=%b expected %o/0", if5.out, if5.err, prev); end
  endtask

  initial begin
    rst = 1'b1;
    if4.game_status = 2'b00; if4.set = 1'b0; if4.random = 1'b0; if4.num = '0;
    if5.game_status = 2'b00; if5.set = 1'b0; if5.random = 1'b0; if5.num = '0;
    test_reset();
    test_index();
    test_index_err();
    test_random();
    test_set_while_busy();
    test_abort();
    test_rst_mid();
    test_n5();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
